// File: rtl/calculadora_seq.sv
`default_nettype none
// ============================================================================
//  Module   : calculadora_seq
//  Purpose  : Sequential four-operation unsigned calculator (10-bit operands)
//             feeding the seven-segment display decoder. Add and subtract
//             complete in one CALC cycle. Multiply is iterative shift-add and
//             divide is restoring division, ten CALC cycles each. Divide by
//             zero completes in one cycle and flags an error.
//  Ports    : clk, rst    - clock, synchronous active-high reset
//             start       - operation request, sampled only in IDLE
//             op[1:0]     - 00 add, 01 sub, 10 mul, 11 div
//             a, b [9:0]  - unsigned operands, latched on accepted start
//             res [9:0]   - registered result, held until next completion
//             busy        - high while in CALC
//             done        - one-cycle pulse when res/erro are updated
//             erro        - error flag of the last completed operation
//  Revision : 1.0 - initial release
// ============================================================================
module calculadora_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] op,
    input  logic [9:0] a,
    input  logic [9:0] b,
    output logic [9:0] res,
    output logic       busy,
    output logic       done,
    output logic       erro
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_FIM  = 2'd2;

    localparam logic [1:0] c_OP_ADD = 2'b00;
    localparam logic [1:0] c_OP_SUB = 2'b01;
    localparam logic [1:0] c_OP_MUL = 2'b10;
    localparam logic [1:0] c_OP_DIV = 2'b11;

    localparam logic [9:0] c_SAT      = 10'd1023;
    localparam logic [3:0] c_LAST_IT  = 4'd9;

    logic [1:0]  r_state;
    logic [1:0]  r_op;
    logic [9:0]  r_a;
    logic [9:0]  r_b;
    logic [19:0] r_acc;
    logic [10:0] r_rem;
    logic [9:0]  r_quo;
    logic [3:0]  r_cnt;

    logic [10:0] w_sum;
    logic [9:0]  w_diff;
    logic [19:0] w_addend;
    logic [19:0] w_acc_next;
    logic [3:0]  w_bitidx;
    logic [10:0] w_rem_sh;
    logic        w_rem_ge;
    logic [10:0] w_rem_next;
    logic [9:0]  w_quo_next;
    logic        w_single;
    logic        w_last;
    logic [9:0]  w_res_val;
    logic        w_erro_val;

    assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff = r_a - r_b;

    // Multiply step i: add A<<i when B[i] is set.
    assign w_addend   = r_b[r_cnt] ? ({10'd0, r_a} << r_cnt) : 20'd0;
    assign w_acc_next = r_acc + w_addend;

    // Divide step i: bring down A[9-i]; the remainder stays below B before
    // the shift, so 11 bits always hold the shifted value.
    assign w_bitidx   = c_LAST_IT - r_cnt;
    assign w_rem_sh   = {r_rem[9:0], r_a[w_bitidx]};
    assign w_rem_ge   = (w_rem_sh >= {1'b0, r_b});
    assign w_rem_next = w_rem_ge ? (w_rem_sh - {1'b0, r_b}) : w_rem_sh;
    // Quotient bits arrive MSB first, so shifting left lands them in place.
    assign w_quo_next = {r_quo[8:0], w_rem_ge};

    assign w_single = (r_op == c_OP_ADD) || (r_op == c_OP_SUB) ||
                      ((r_op == c_OP_DIV) && (r_b == 10'd0));
    assign w_last   = (r_cnt == c_LAST_IT);

    // Final value loaded into res/erro on the cycle that leaves CALC. For
    // mul/div this uses the step being completed in that same cycle.
    always_comb begin
        w_res_val  = 10'd0;
        w_erro_val = 1'b0;
        case (r_op)
            c_OP_ADD: begin
                if (w_sum[10]) begin
                    w_res_val  = c_SAT;
                    w_erro_val = 1'b1;
                end else begin
                    w_res_val  = w_sum[9:0];
                end
            end
            c_OP_SUB: begin
                if (r_a < r_b) begin
                    w_res_val  = 10'd0;
                    w_erro_val = 1'b1;
                end else begin
                    w_res_val  = w_diff;
                end
            end
            c_OP_MUL: begin
                if (w_acc_next > {10'd0, c_SAT}) begin
                    w_res_val  = c_SAT;
                    w_erro_val = 1'b1;
                end else begin
                    w_res_val  = w_acc_next[9:0];
                end
            end
            default: begin
                if (r_b == 10'd0) begin
                    w_res_val  = c_SAT;
                    w_erro_val = 1'b1;
                end else begin
                    w_res_val  = w_quo_next;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_op    <= 2'd0;
            r_a     <= 10'd0;
            r_b     <= 10'd0;
            r_acc   <= 20'd0;
            r_rem   <= 11'd0;
            r_quo   <= 10'd0;
            r_cnt   <= 4'd0;
            res     <= 10'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            erro    <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_op    <= op;
                        r_a     <= a;
                        r_b     <= b;
                        r_acc   <= 20'd0;
                        r_rem   <= 11'd0;
                        r_quo   <= 10'd0;
                        r_cnt   <= 4'd0;
                        busy    <= 1'b1;
                        r_state <= c_CALC;
                    end
                end
                c_CALC: begin
                    r_cnt <= r_cnt + 4'd1;
                    r_acc <= w_acc_next;
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    if (w_single || w_last) begin
                        res     <= w_res_val;
                        erro    <= w_erro_val;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= c_FIM;
                    end
                end
                c_FIM: begin
                    done    <= 1'b0;
                    r_state <= c_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_calculadora_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_calculadora_seq
//  Purpose  : Self-checking bench for calculadora_seq. Table of directed
//             operations with hand-computed results and latencies, plus
//             sequences for input changes while busy, back-to-back starts
//             and reset during a multiply.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_calculadora_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] op;
    logic [9:0] a;
    logic [9:0] b;
    logic [9:0] res;
    logic       busy;
    logic       done;
    logic       erro;

    int checks   = 0;
    int failures = 0;
    int prev_res = 0;

    calculadora_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .res   (res),
        .busy  (busy),
        .done  (done),
        .erro  (erro)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    // busy and done must never be high together.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (busy && done) begin
                failures++;
                $display("FAIL busy_done_overlap actual=1 required=0 t=%0t", $time);
            end
        end
    end

    typedef struct {
        logic [1:0] op;
        logic [9:0] a;
        logic [9:0] b;
        logic [9:0] res;
        logic       err;
        int         k;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // One full operation: start for one cycle, measure latency to done,
    // check result/flags, then check done drops after one cycle.
    task automatic do_op(input logic [1:0] o, input logic [9:0] x, input logic [9:0] y,
                         input logic [9:0] er, input logic ee, input int k, input string nm);
        int lat;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        chk({nm, "_busy"}, busy, 1);
        chk({nm, "_res_held"}, res, prev_res);
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, "_done"}, done, 1);
        chk({nm, "_latency"}, lat, k);
        chk({nm, "_res"}, res, er);
        chk({nm, "_erro"}, erro, ee);
        chk({nm, "_busy_at_done"}, busy, 0);
        @(negedge clk);
        chk({nm, "_done_drop"}, done, 0);
        chk({nm, "_res_stable"}, res, er);
        prev_res = er;
    endtask

    initial begin
        int ndone;
        int t1, t2, cyc;

        vecs[0]  = '{2'b00, 10'd600,  10'd300,  10'd900,  1'b0, 1};
        vecs[1]  = '{2'b00, 10'd1000, 10'd100,  10'd1023, 1'b1, 1};
        vecs[2]  = '{2'b00, 10'd512,  10'd511,  10'd1023, 1'b0, 1};
        vecs[3]  = '{2'b00, 10'd512,  10'd512,  10'd1023, 1'b1, 1};
        vecs[4]  = '{2'b01, 10'd5,    10'd9,    10'd0,    1'b1, 1};
        vecs[5]  = '{2'b01, 10'd9,    10'd5,    10'd4,    1'b0, 1};
        vecs[6]  = '{2'b01, 10'd7,    10'd7,    10'd0,    1'b0, 1};
        vecs[7]  = '{2'b10, 10'd31,   10'd33,   10'd1023, 1'b0, 10};
        vecs[8]  = '{2'b10, 10'd32,   10'd32,   10'd1023, 1'b1, 10};
        vecs[9]  = '{2'b10, 10'd0,    10'd1023, 10'd0,    1'b0, 10};
        vecs[10] = '{2'b10, 10'd13,   10'd11,   10'd143,  1'b0, 10};
        vecs[11] = '{2'b11, 10'd1000, 10'd7,    10'd142,  1'b0, 10};
        vecs[12] = '{2'b11, 10'd5,    10'd0,    10'd1023, 1'b1, 1};
        vecs[13] = '{2'b11, 10'd3,    10'd1023, 10'd0,    1'b0, 10};
        vecs[14] = '{2'b11, 10'd1023, 10'd1,    10'd1023, 1'b0, 10};
        vecs[15] = '{2'b11, 10'd1023, 10'd1023, 10'd1,    1'b0, 10};

        rst = 1'b1; start = 1'b0; op = 2'b00; a = 10'd0; b = 10'd0;
        repeat (3) @(negedge clk);
        chk("reset_res", res, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_erro", erro, 0);
        rst = 1'b0;

        foreach (vecs[i])
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].err,
                  vecs[i].k, $sformatf("vec%0d", i));

        // Mul 20*30 while inputs churn and start pulses during CALC/FIM.
        @(negedge clk);
        start = 1'b1; op = 2'b10; a = 10'd20; b = 10'd30;
        ndone = 0;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            if (done) ndone++;
            a = 10'($urandom); b = 10'($urandom); op = 2'($urandom);
            start = 1'($urandom);
        end
        start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("churn_done_count", ndone, 1);
        chk("churn_res", res, 600);
        chk("churn_erro", erro, 0);
        prev_res = 600;

        // start held high: add 1+1 back to back, done period k+2 = 3.
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 10'd1; b = 10'd1;
        t1 = -1; t2 = -1; cyc = 0;
        while (t2 < 0 && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                if (t1 < 0) t1 = cyc;
                else t2 = cyc;
            end
        end
        start = 1'b0;
        chk("b2b_period", t2 - t1, 3);
        chk("b2b_res", res, 2);
        repeat (5) @(negedge clk);
        prev_res = 2;

        // Reset at the 5th CALC cycle of a multiply.
        do_op(2'b11, 10'd5, 10'd0, 10'd1023, 1'b1, 1, "pre_rst");
        @(negedge clk);
        start = 1'b1; op = 2'b10; a = 10'd20; b = 10'd30;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrst_busy_before", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_res", res, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_erro", erro, 0);
        ndone = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("midrst_no_done", ndone, 0);
        prev_res = 0;
        do_op(2'b00, 10'd1, 10'd2, 10'd3, 1'b0, 1, "post_rst_add");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
